snake_grid_arbiter: RTL and testbench

Owns the single-port snake grid RAM (30x17 cells, one code per cell). It shares that RAM between the LCD pixel-fetch path and the game-update logic.
- Display reads always win.
- Game reads/writes are granted only inside a blanking window, which opens on each vertical sync and closes at the first active pixel.
- The block also schedules game steps: it emits step_tick every frame_div frames, and frame_div is adjustable by speed pulses.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_step_timer.sv | 63 ++++++
 rtl/snake_grid_arbiter.sv | 124 ++++++++++++
 tb/tb_snake_grid_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake grid RAM arbiter and its step timer.
// Latency: none, because this file holds only declarations.
// Backpressure: none, because this file holds only declarations.
package snake_pkg;

  localparam int GRID_W = 30;
  localparam int GRID_H = 17;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 4;

  typedef enum logic [DATA_W-1:0] {
    CELL_EMPTY = 4'd0,
    CELL_BODY  = 4'd1,
    CELL_HEAD  = 4'd2,
    CELL_FOOD  = 4'd3,
    CELL_WALL  = 4'd4
  } cell_t;

  typedef enum logic {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_GAME = 2'd2
  } owner_t;

endpackage

// File: rtl/snake_step_timer.sv
// Counts vsync falling edges and pulses step_tick once every frame_div frames.
// Latency: vs_fall is combinational; step_tick is asserted 1 cycle after the qualifying edge.
// Backpressure: none. Speed pulses saturate at DIV_MIN and DIV_MAX.
module snake_step_timer #(
  parameter int DIV_INIT = 8,
  parameter int DIV_MIN  = 2,
  parameter int DIV_MAX  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_vsync,
  input  logic       speed_up,
  input  logic       speed_down,
  output logic       vs_fall,
  output logic       step_tick,
  output logic [4:0] frame_div
);

  localparam logic [4:0] DIV_INIT_V = 5'(DIV_INIT);
  localparam logic [4:0] DIV_MIN_V  = 5'(DIV_MIN);
  localparam logic [4:0] DIV_MAX_V  = 5'(DIV_MAX);

  logic       vs_d;
  logic [4:0] frame_cnt;

  assign vs_fall = vs_d & ~lcd_vsync;

  // Delay vsync by one cycle for edge detection; idle-high so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vs_d <= 1'b1;
    else      vs_d <= lcd_vsync;
  end

  // Count frames and fire a one-cycle tick when the count reaches the current divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 5'd0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (vs_fall) begin
        if (frame_cnt >= frame_div - 5'd1) begin
          frame_cnt <= 5'd0;
          step_tick <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 5'd1;
        end
      end
    end
  end

  // Adjust the divider with saturation; simultaneous up and down pulses cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_div <= DIV_INIT_V;
    end else if (speed_up && !speed_down && frame_div > DIV_MIN_V) begin
      frame_div <= frame_div - 5'd1;
    end else if (speed_down && !speed_up && frame_div < DIV_MAX_V) begin
      frame_div <= frame_div + 5'd1;
    end
  end

endmodule

// File: rtl/snake_grid_arbiter.sv
// Shares the single-port grid RAM between display fetch (always wins) and game access (blanking only).
// Latency: RAM strobes and gl_gnt are registered 1 cycle after select; rvalid follows 1 cycle after ram_en.
// Backpressure: a game request stalls with gl_gnt=0 while the display reads or the window is shut.
module snake_grid_arbiter
  import snake_pkg::*;
#(
  parameter int DIV_INIT = 8,
  parameter int DIV_MIN  = 2,
  parameter int DIV_MAX  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_vsync,
  input  logic              lcd_de,
  input  logic              disp_rd_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  input  logic              speed_up,
  input  logic              speed_down,
  output logic              step_tick,
  output logic              window_open,
  output logic [4:0]        frame_div,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t state, state_nxt;
  owner_t     issue_tag;
  logic       vs_fall;
  logic       sel_disp;
  logic       sel_game;

  snake_step_timer #(
    .DIV_INIT (DIV_INIT),
    .DIV_MIN  (DIV_MIN),
    .DIV_MAX  (DIV_MAX)
  ) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .lcd_vsync  (lcd_vsync),
    .speed_up   (speed_up),
    .speed_down (speed_down),
    .vs_fall    (vs_fall),
    .step_tick  (step_tick),
    .frame_div  (frame_div)
  );

  // Window tracking and RAM owner selection; the game is never picked in a cycle that sees lcd_de.
  always_comb begin
    state_nxt = state;
    sel_disp  = disp_rd_en;
    sel_game  = 1'b0;
    case (state)
      ACTIVE: begin
        if (vs_fall) state_nxt = BLANK;
      end
      BLANK: begin
        if (lcd_de) state_nxt = ACTIVE;
        sel_game = !disp_rd_en && gl_req && !lcd_de;
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  // Window state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACTIVE;
    else      state <= state_nxt;
  end

  assign window_open = (state == BLANK);

  // Register the RAM strobes, the grant and the owner tag of the issued read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      gl_gnt    <= 1'b0;
      issue_tag <= TAG_NONE;
    end else begin
      ram_en <= sel_disp | sel_game;
      ram_we <= sel_game & gl_we;
      gl_gnt <= sel_game;
      if (sel_disp) begin
        ram_addr  <= disp_addr;
        issue_tag <= TAG_DISP;
      end else if (sel_game) begin
        ram_addr  <= gl_addr;
        ram_wdata <= gl_wdata;
        issue_tag <= gl_we ? TAG_NONE : TAG_GAME;
      end else begin
        issue_tag <= TAG_NONE;
      end
    end
  end

  // Route the returning read to its owner the cycle after the RAM strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_rvalid <= 1'b0;
      gl_rvalid   <= 1'b0;
    end else begin
      disp_rvalid <= (issue_tag == TAG_DISP);
      gl_rvalid   <= (issue_tag == TAG_GAME);
    end
  end

  assign disp_rdata = disp_rvalid ? ram_rdata : '0;
  assign gl_rdata   = gl_rvalid   ? ram_rdata : '0;

endmodule

// File: tb/tb_snake_grid_arbiter.sv
// Directed bench for snake_grid_arbiter with a sync RAM, a frame/window/scoreboard model and per-cycle compare.
// Latency: n/a. The model predicts each registered output for the cycle after every clock edge.
// Backpressure: game requests are held until gl_gnt is seen, bounded by a cycle budget.
module tb_snake_grid_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_vsync, lcd_de, disp_rd_en, gl_req, gl_we, speed_up, speed_down;
  logic [8:0] disp_addr, gl_addr, ram_addr;
  logic [3:0] gl_wdata, disp_rdata, gl_rdata, ram_wdata;
  logic [3:0] ram_rdata = 4'd0;
  logic       disp_rvalid, gl_gnt, gl_rvalid, step_tick, window_open, ram_en, ram_we;
  logic [4:0] frame_div;

  int n_checks = 0;
  int n_fail   = 0;

  snake_grid_arbiter dut (
    .clk(clk), .rst(rst), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .disp_rd_en(disp_rd_en), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
    .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
    .speed_up(speed_up), .speed_down(speed_down), .step_tick(step_tick),
    .window_open(window_open), .frame_div(frame_div),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous grid RAM.
  logic [3:0] mem    [0:509];
  logic [3:0] shadow [0:509];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frames since last step, divider, window flag, and a one-deep read return queue.
  int         m_cnt, m_div, pend_owner;
  bit         m_prev_vs, x_win, x_tick, x_gnt, x_en, x_we, x_drv, x_grv, fall, dsel, gsel;
  logic [8:0] x_addr;
  logic [3:0] x_wdata, x_rdata, pend_data;

  // Predict the outputs visible after this edge from the inputs held across it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_div = 8; x_win = 0; m_prev_vs = 1; pend_owner = 0; pend_data = 0;
      x_tick = 0; x_gnt = 0; x_en = 0; x_we = 0; x_drv = 0; x_grv = 0;
      x_addr = 0; x_wdata = 0; x_rdata = 0;
    end else begin
      x_drv = (pend_owner == 1);
      x_grv = (pend_owner == 2);
      x_rdata = pend_data;
      pend_owner = 0;
      fall = m_prev_vs && !lcd_vsync;
      m_prev_vs = lcd_vsync;
      dsel = disp_rd_en;
      gsel = !disp_rd_en && x_win && gl_req && !lcd_de;
      x_en = dsel || gsel;
      x_gnt = gsel;
      x_we = 0;
      if (dsel) begin
        x_addr = disp_addr; pend_owner = 1; pend_data = shadow[disp_addr];
      end else if (gsel) begin
        x_addr = gl_addr; x_we = gl_we;
        if (gl_we) begin x_wdata = gl_wdata; shadow[gl_addr] = gl_wdata; end
        else begin pend_owner = 2; pend_data = shadow[gl_addr]; end
      end
      if (x_win) begin
        if (lcd_de) x_win = 0;
      end else if (fall) begin
        x_win = 1;
      end
      x_tick = 0;
      if (fall) begin
        if (m_cnt + 1 >= m_div) begin x_tick = 1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end
      if (speed_up && !speed_down) m_div = (m_div > 2) ? m_div - 1 : 2;
      if (speed_down && !speed_up) m_div = (m_div < 30) ? m_div + 1 : 30;
    end
  end

  // Compare every registered output against the model mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("step_tick", step_tick, x_tick);
      chk("window_open", window_open, x_win);
      chk("frame_div", frame_div, m_div);
      chk("gl_gnt", gl_gnt, x_gnt);
      chk("ram_en", ram_en, x_en);
      if (x_en) begin
        chk("ram_we", ram_we, x_we);
        chk("ram_addr", ram_addr, x_addr);
        if (x_we) chk("ram_wdata", ram_wdata, x_wdata);
      end
      chk("disp_rvalid", disp_rvalid, x_drv);
      chk("gl_rvalid", gl_rvalid, x_grv);
      if (x_drv) chk("disp_rdata", disp_rdata, x_rdata);
      if (x_grv) chk("gl_rdata", gl_rdata, x_rdata);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic close_win;
    lcd_de = 1; cyc(); lcd_de = 0; cyc();
  endtask

  task automatic vs_fall_ev(output bit tk, output bit wo);
    lcd_vsync = 0; cyc(); tk = step_tick; wo = window_open;
    lcd_vsync = 1; cyc();
  endtask

  task automatic pulse_speed(input bit up, input bit dn);
    speed_up = up; speed_down = dn; cyc(); speed_up = 0; speed_down = 0;
  endtask

  task automatic gl_access(input bit we, input int a, input int d, output int wait_cyc);
    gl_req = 1; gl_we = we; gl_addr = 9'(a); gl_wdata = 4'(d); wait_cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (gl_gnt) begin wait_cyc = i; break; end
    end
    gl_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit tk, wo;
    int ticks, w, g;
    for (int i = 0; i < 510; i++) begin mem[i] = 4'(i % 5); shadow[i] = 4'(i % 5); end
    rst = 0; lcd_vsync = 1; lcd_de = 0; disp_rd_en = 0; disp_addr = 0;
    gl_req = 0; gl_we = 0; gl_addr = 0; gl_wdata = 0; speed_up = 0; speed_down = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step_tick", step_tick, 0);
    chk("rst_window", window_open, 0);
    chk("rst_frame_div", frame_div, 8);
    chk("rst_gnt", gl_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rvalid", disp_rvalid | gl_rvalid, 0);
    rst = 1;
    cyc();

    // Eight frames at the default divider: one tick, right after the 8th fall.
    ticks = 0;
    for (int i = 1; i <= 8; i++) begin
      close_win();
      vs_fall_ev(tk, wo);
      ticks += int'(tk);
      if (i == 8) begin chk("tick_on_8th", tk, 1); chk("win_with_tick", wo, 1); end
    end
    chk("ticks_in_8", ticks, 1);

    // Six frames in, shrink divider to 5: the next fall ticks, then five more frames to the next.
    for (int i = 1; i <= 6; i++) begin close_win(); vs_fall_ev(tk, wo); chk("no_tick_pre", tk, 0); end
    repeat (3) pulse_speed(1, 0);
    chk("div_after_3up", frame_div, 5);
    close_win(); vs_fall_ev(tk, wo); chk("tick_after_shrink", tk, 1);
    for (int i = 1; i <= 5; i++) begin
      close_win(); vs_fall_ev(tk, wo);
      chk("cnt_restart", tk, (i == 5) ? 1 : 0);
    end

    // Divider saturation and cancelling pulses.
    repeat (3) pulse_speed(0, 1);
    chk("div_back_8", frame_div, 8);
    repeat (10) pulse_speed(1, 0);
    chk("div_sat_min", frame_div, 2);
    repeat (40) pulse_speed(0, 1);
    chk("div_sat_max", frame_div, 30);
    pulse_speed(1, 1);
    cyc();
    chk("div_both", frame_div, 30);

    // Blanking write then read of cell 37; the read returns even though the window shuts after it.
    close_win(); vs_fall_ev(tk, wo); chk("win_open", wo, 1);
    gl_access(1, 37, 3, w); chk("wr_gnt_wait", w, 1);
    gl_access(0, 37, 0, w); chk("rd_gnt_wait", w, 1);
    lcd_de = 1; cyc(); lcd_de = 0;
    chk("rd_rvalid", gl_rvalid, 1);
    chk("rd_rdata", gl_rdata, 3);
    chk("win_closed", window_open, 0);

    // Display beats the game inside the window.
    vs_fall_ev(tk, wo);
    disp_rd_en = 1; disp_addr = 37; gl_req = 1; gl_we = 0; gl_addr = 101;
    cyc(); chk("disp_wins_gnt", gl_gnt, 0); chk("disp_wins_addr", ram_addr, 37);
    cyc(); chk("disp_rvalid", disp_rvalid, 1); chk("disp_rdata37", disp_rdata, 3); chk("disp_hold_gnt", gl_gnt, 0);
    disp_rd_en = 0;
    cyc(); chk("gnt_after_disp", gl_gnt, 1); chk("gnt_addr", ram_addr, 101);
    gl_req = 0;
    cyc(); chk("gl_rvalid101", gl_rvalid, 1); chk("gl_rdata101", gl_rdata, 1);

    // Game request stalls through an active frame while the display keeps fetching.
    close_win();
    gl_req = 1; gl_we = 1; gl_addr = 200; gl_wdata = 4;
    g = 0;
    for (int i = 0; i < 100; i++) begin
      disp_rd_en = (i % 3 == 0); disp_addr = 9'((i * 5) % 510);
      cyc(); g += int'(gl_gnt);
    end
    disp_rd_en = 0;
    chk("active_no_gnt", g, 0);
    lcd_vsync = 0;
    cyc(); chk("gnt_edge_p1", gl_gnt, 0);
    cyc(); chk("gnt_edge_p2", gl_gnt, 1);
    gl_req = 0; lcd_vsync = 1;
    gl_req = 1; gl_we = 0; gl_addr = 200; lcd_de = 1;
    cyc(); chk("de_close_win", window_open, 0); chk("de_no_gnt", gl_gnt, 0);
    lcd_de = 0;
    g = 0;
    repeat (5) begin cyc(); g += int'(gl_gnt); end
    chk("closed_no_gnt", g, 0);
    lcd_vsync = 0;
    gl_access(0, 200, 0, w); chk("pending_gnt_wait", w, 2);
    lcd_vsync = 1;
    cyc(); chk("rd200_rvalid", gl_rvalid, 1); chk("rd200_rdata", gl_rdata, 4);

    // Asynchronous reset mid-operation.
    pulse_speed(1, 0);
    disp_rd_en = 1; disp_addr = 5;
    cyc();
    @(posedge clk); #3 rst = 0; #1;
    chk("mid_rst_div", frame_div, 8);
    chk("mid_rst_win", window_open, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_rvalid", disp_rvalid, 0);
    disp_rd_en = 0;
    cyc(); rst = 1; cyc();
    close_win(); vs_fall_ev(tk, wo); chk("post_rst_win", wo, 1); chk("post_rst_tick", tk, 0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
